// File: rtl/i2c_slave_regs.sv
// I2C target that turns bus transfers into single-cycle register-file read/write strobes.
// Optional macro I2C_SLAVE_AUTOINC_EN: pointer auto-increments after every reg_we/reg_re.
module i2c_slave_regs #(
    parameter logic [6:0] DEVICE_ADDR = 7'b101_0000,
    parameter int         ADDR_BYTES  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, ADDR_H, ACK_H, ADDR_L, ACK_L,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_e;

    // [1:0] are the two synchronizer flops, [2] is the edge-detect history
    logic [2:0]  scl_sync_q, sda_sync_q;
    logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic [7:0]  addr_h_q, addr_h_d;
    logic [15:0] ptr_q, ptr_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rd_pend_q;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_sync_q[2];
    assign scl_fall  = ~scl_s & scl_sync_q[2];
    assign start_det = scl_s & scl_sync_q[2] & sda_sync_q[2] & ~sda_s;
    assign stop_det  = scl_s & scl_sync_q[2] & ~sda_sync_q[2] & sda_s;

    function automatic logic [15:0] ptr_inc(input logic [15:0] p);
        if (ADDR_BYTES == 1) return {8'h00, p[7:0] + 8'd1};
        else                 return p + 16'd1;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        addr_h_d  = addr_h_q;
        ptr_d     = ptr_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        wdata_d   = wdata_q;
`ifdef I2C_SLAVE_AUTOINC_EN
        if (we_q || re_q) ptr_d = ptr_inc(ptr_q);
`endif
        if (start_det) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR, ADDR_H, ADDR_L, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                DEV_ADDR: begin
                                    if (shift_q[6:0] == DEVICE_ADDR) begin
                                        state_d = DEV_ACK;
                                        busy_d  = 1'b1;
                                        rw_d    = sda_s;
                                    end else begin
                                        state_d = IGNORE;
                                    end
                                end
                                ADDR_H: begin
                                    addr_h_d = shift_d;
                                    state_d  = ACK_H;
                                end
                                ADDR_L:  state_d = ACK_L;
                                default: begin
                                    we_d    = 1'b1;
                                    wdata_d = shift_d;
                                    state_d = WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                // Ack slot: pull low on the 8th falling edge, let go on the 9th
                DEV_ACK, ACK_H, ACK_L, WR_ACK: begin
                    if (scl_rise && state_q == DEV_ACK && rw_q) re_d = 1'b1;
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = 4'd0;
                            case (state_q)
                                DEV_ACK: begin
                                    if (rw_q) begin
                                        state_d = RD_DATA;
                                        oe_d    = ~tx_q[7];
                                    end else if (ADDR_BYTES == 2) begin
                                        state_d = ADDR_H;
                                    end else begin
                                        state_d  = ADDR_L;
                                        addr_h_d = 8'h00;
                                    end
                                end
                                ACK_H: state_d = ADDR_L;
                                ACK_L: begin
                                    state_d = WR_DATA;
                                    ptr_d   = {addr_h_q, shift_q};
                                end
                                default: state_d = WR_DATA;
                            endcase
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q >= 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = RD_ACK;
                        end else begin
                            oe_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = IGNORE;
                        else       re_d    = 1'b1;
                    end
                    if (scl_fall) begin
                        state_d   = RD_DATA;
                        bit_cnt_d = 4'd0;
                        oe_d      = ~tx_q[7];
                    end
                end
                default: oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (sys_rst) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            addr_h_q   <= 8'h00;
            ptr_q      <= 16'h0000;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            wdata_q    <= 8'h00;
            rd_pend_q  <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], i2c_scl};
            sda_sync_q <= {sda_sync_q[1:0], i2c_sda};
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            addr_h_q   <= addr_h_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            re_q       <= re_d;
            wdata_q    <= wdata_d;
            rd_pend_q  <= re_q;
            // reg_rdata is valid the cycle after reg_re
            if (rd_pend_q) tx_q <= reg_rdata;
        end
    end

    assign i2c_sda   = oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = ptr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;

endmodule
